// File: rtl/rs485_apb_fifo_ctrl_if.sv
// rtl/rs485_apb_fifo_ctrl_if.sv - APB register bus plus serialiser stream signals of the RS-485 FIFO controller
interface rs485_apb_fifo_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [7:0]        paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              de;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, tx_ready, rx_data, rx_valid,
    output prdata, pready, pslverr, tx_data, tx_valid, de
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata, tx_ready, rx_data, rx_valid,
    input  prdata, pready, pslverr, tx_data, tx_valid, de
  );
endinterface

// File: rtl/rs485_apb_fifo_ctrl.sv
// rtl/rs485_apb_fifo_ctrl.sv - APB-mapped TX/RX FIFOs with guarded driver-enable FSM for a half-duplex RS-485 link
// Optional irq output and 0x14 IRQ_MASK register are built only when RS485_IRQ_EN is defined.
module rs485_apb_fifo_ctrl #(
  parameter int DATA_W    = 16,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16,
  parameter int GUARD_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rs485_apb_fifo_ctrl_if.slave bus
`ifdef RS485_IRQ_EN
  ,
  output logic                 irq
`endif
);
  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam int GW  = $clog2(GUARD_CYC + 1);
  localparam logic [TXA:0]  TX_FULL_LVL = (TXA + 1)'(TX_DEPTH);
  localparam logic [RXA:0]  RX_FULL_LVL = (RXA + 1)'(RX_DEPTH);
  localparam logic [GW-1:0] GUARD_LAST  = GW'(GUARD_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
  logic [DATA_W-1:0] tx_mem_d [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
  logic [DATA_W-1:0] rx_mem_d [RX_DEPTH];
  logic [TXA-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [RXA-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [TXA:0]   tx_level_q, tx_level_d;
  logic [RXA:0]   rx_level_q, rx_level_d;
  logic [1:0]     state_q, state_d;
  logic [GW-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic tx_valid_q, tx_valid_d, enable_q, enable_d, rx_ovf_q, rx_ovf_d;

  logic wr_acc, rd_acc, a_tx, a_rx, a_ctrl, a_stat, a_lvl, a_irq;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_push, tx_pop, rx_push, rx_pop, rx_in;
  logic tx_flush, rx_flush, de, free;
  logic [31:0] rdata;
  logic unused_pwdata;

  assign wr_acc = bus.psel & bus.penable & bus.pwrite;
  assign rd_acc = bus.psel & bus.penable & ~bus.pwrite;
  assign a_tx   = bus.paddr == 8'h00;
  assign a_rx   = bus.paddr == 8'h04;
  assign a_ctrl = bus.paddr == 8'h08;
  assign a_stat = bus.paddr == 8'h0C;
  assign a_lvl  = bus.paddr == 8'h10;
  assign a_irq  = bus.paddr == 8'h14;
  assign unused_pwdata = ^bus.pwdata;

  assign tx_full  = tx_level_q == TX_FULL_LVL;
  assign tx_empty = tx_level_q == '0;
  assign rx_full  = rx_level_q == RX_FULL_LVL;
  assign rx_empty = rx_level_q == '0;
  assign de       = state_q != S_IDLE;

  assign tx_flush = wr_acc & a_ctrl & bus.pwdata[1];
  assign rx_flush = wr_acc & a_ctrl & bus.pwdata[2];
  assign tx_push  = wr_acc & a_tx & ~tx_full;
  assign rx_in    = bus.rx_valid & enable_q & ~de;
  assign rx_push  = rx_in & ~rx_full;
  assign rx_pop   = rd_acc & a_rx & ~rx_empty;
  assign free     = ~tx_valid_q | bus.tx_ready;

  // Staging is free again on the handshake edge, so back-to-back words need no idle cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable_q && !tx_empty) state_d = S_SETUP;
      end
      S_SETUP, S_HOLD: begin
        if (cnt_q == GUARD_LAST) begin
          cnt_d   = '0;
          state_d = (state_q == S_SETUP) ? S_SEND : S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (tx_valid_q && bus.tx_ready) tx_valid_d = 1'b0;
        if (free) begin
          if (enable_q && !tx_empty && !tx_flush) begin
            tx_pop     = 1'b1;
            tx_valid_d = 1'b1;
            tx_data_d  = tx_mem_q[tx_rptr_q];
          end else if (!enable_q || tx_empty) begin
            state_d = S_HOLD;
          end
        end
      end
    endcase
  end

  always_comb begin
    tx_mem_d   = tx_mem_q;
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    tx_level_d = tx_level_q;
    if (tx_push) tx_mem_d[tx_wptr_q] = bus.pwdata[DATA_W-1:0];
    if (tx_flush) begin
      tx_wptr_d  = '0;
      tx_rptr_d  = '0;
      tx_level_d = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_d = tx_rptr_q + 1'b1;
      if (tx_push && !tx_pop) tx_level_d = tx_level_q + 1'b1;
      if (!tx_push && tx_pop) tx_level_d = tx_level_q - 1'b1;
    end
  end

  always_comb begin
    rx_mem_d   = rx_mem_q;
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    rx_level_d = rx_level_q;
    if (rx_push) rx_mem_d[rx_wptr_q] = bus.rx_data;
    if (rx_flush) begin
      rx_wptr_d  = '0;
      rx_rptr_d  = '0;
      rx_level_d = '0;
    end else begin
      if (rx_push) rx_wptr_d = rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_d = rx_rptr_q + 1'b1;
      if (rx_push && !rx_pop) rx_level_d = rx_level_q + 1'b1;
      if (!rx_push && rx_pop) rx_level_d = rx_level_q - 1'b1;
    end
  end

  // An overflow in the same cycle as a software clear keeps the flag set.
  always_comb begin
    enable_d = (wr_acc && a_ctrl) ? bus.pwdata[0] : enable_q;
    rx_ovf_d = rx_ovf_q;
    if (wr_acc && a_stat && bus.pwdata[4]) rx_ovf_d = 1'b0;
    if (rx_in && rx_full)                  rx_ovf_d = 1'b1;
  end

`ifdef RS485_IRQ_EN
  logic [2:0] irq_mask_q, irq_mask_d;
  logic       irq_q, irq_d;

  always_comb begin
    irq_mask_d = (wr_acc && a_irq) ? bus.pwdata[2:0] : irq_mask_q;
    irq_d      = |(irq_mask_q & {rx_ovf_q, ~rx_empty, tx_empty});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_mask_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    rdata = '0;
    if (rd_acc) begin
      if (a_rx && !rx_empty) rdata = 32'(rx_mem_q[rx_rptr_q]);
      if (a_ctrl) rdata = {31'b0, enable_q};
      if (a_stat) rdata = {27'b0, rx_ovf_q, rx_full, rx_empty, tx_full, tx_empty};
      if (a_lvl)  rdata = {16'(rx_level_q), 16'(tx_level_q)};
`ifdef RS485_IRQ_EN
      if (a_irq)  rdata = {29'b0, irq_mask_q};
`else
      if (a_irq)  rdata = '0;
`endif
    end
  end

  assign bus.prdata   = rdata;
  assign bus.pready   = 1'b1;
  assign bus.pslverr  = (wr_acc & a_tx & tx_full) | (rd_acc & a_rx & rx_empty);
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.de       = de;

  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      enable_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_level_q <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_level_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      enable_q   <= enable_d;
      rx_ovf_q   <= rx_ovf_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_level_q <= tx_level_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_level_q <= rx_level_d;
    end
  end
endmodule

// File: tb/tb_rs485_apb_fifo_ctrl.sv
// tb/tb_rs485_apb_fifo_ctrl.sv - directed vector bench for rs485_apb_fifo_ctrl
module tb_rs485_apb_fifo_ctrl;
  localparam int G = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
`ifdef RS485_IRQ_EN
  logic irq;
`endif

  always #5 clk = ~clk;

  rs485_apb_fifo_ctrl_if #(.DATA_W(16)) bus ();

  rs485_apb_fifo_ctrl #(
    .DATA_W(16), .TX_DEPTH(16), .RX_DEPTH(16), .GUARD_CYC(G)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef RS485_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    @(negedge clk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
    @(negedge clk);
    bus.penable = 1'b1;
    #1;
    rd  = bus.prdata;
    err = bus.pslverr;
    @(posedge clk);
    #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic rx_word(input logic [15:0] d);
    @(negedge clk);
    bus.rx_data = d; bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int n = 0; n < 40 && !bus.tx_valid; n++) begin
      @(posedge clk);
      #1;
    end
    check(name, 32'(bus.tx_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          k_valid;
    int          k_fall;
    logic [15:0] seen;

    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
    bus.tx_ready = 0; bus.rx_data = 0; bus.rx_valid = 0;

    vecs[0]  = '{1'b0, 8'h0C, 32'h0,        32'h5,    1'b0};
    vecs[1]  = '{1'b0, 8'h10, 32'h0,        32'h0,    1'b0};
    vecs[2]  = '{1'b0, 8'h08, 32'h0,        32'h0,    1'b0};
    vecs[3]  = '{1'b0, 8'h04, 32'h0,        32'h0,    1'b1};
    vecs[4]  = '{1'b0, 8'h20, 32'h0,        32'h0,    1'b0};
    vecs[5]  = '{1'b1, 8'h20, 32'hFFFFFFFF, 32'h0,    1'b0};
    vecs[6]  = '{1'b0, 8'h14, 32'h0,        32'h0,    1'b0};
    vecs[7]  = '{1'b1, 8'h08, 32'h1,        32'h0,    1'b0};
    vecs[8]  = '{1'b0, 8'h08, 32'h0,        32'h1,    1'b0};
    vecs[9]  = '{1'b1, 8'h08, 32'h7,        32'h0,    1'b0};
    vecs[10] = '{1'b0, 8'h08, 32'h0,        32'h1,    1'b0};
    vecs[11] = '{1'b1, 8'h08, 32'h0,        32'h0,    1'b0};
    vecs[12] = '{1'b0, 8'h08, 32'h0,        32'h0,    1'b0};
    vecs[13] = '{1'b1, 8'h00, 32'h1234,     32'h0,    1'b0};
    vecs[14] = '{1'b0, 8'h10, 32'h0,        32'h1,    1'b0};
    vecs[15] = '{1'b0, 8'h0C, 32'h0,        32'h4,    1'b0};
    vecs[16] = '{1'b1, 8'h08, 32'h2,        32'h0,    1'b0};
    vecs[17] = '{1'b0, 8'h10, 32'h0,        32'h0,    1'b0};
    vecs[18] = '{1'b0, 8'h0C, 32'h0,        32'h5,    1'b0};
    vecs[19] = '{1'b0, 8'h00, 32'h0,        32'h0,    1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_de", 32'(bus.de), 32'd0);
    check("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("reset_tx_data", 32'(bus.tx_data), 32'd0);
    check("pready", 32'(bus.pready), 32'd1);

    for (int i = 0; i < 20; i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_pslverr", i), 32'(err), 32'(vecs[i].exp_err));
    end

    // Single word: de timing and first-valid latency measured from the push edge
    bus.tx_ready = 1'b1;
    apb(1, 8'h08, 32'h1, rd, err);
    apb(1, 8'h00, 32'hA5A5, rd, err);
    check("t1_de_before", 32'(bus.de), 32'd0);
    k_valid = -1; k_fall = -1; seen = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) check("t1_de_rise", 32'(bus.de), 32'd1);
      if (bus.tx_valid && k_valid < 0) begin k_valid = k; seen = bus.tx_data; end
      if (!bus.de && k > 1 && k_fall < 0) k_fall = k;
    end
    check("t1_valid_latency", 32'(k_valid), 32'(G + 2));
    check("t1_tx_data", 32'(seen), 32'hA5A5);
    check("t1_de_fall", 32'(k_fall), 32'(2 * G + 3));

    // TX overflow with enable=0
    apb(1, 8'h08, 32'h0, rd, err);
    for (int i = 0; i < 17; i++) begin
      apb(1, 8'h00, 32'h100 + 32'(i), rd, err);
      check($sformatf("t2_push%0d_err", i), 32'(err), (i == 16) ? 32'd1 : 32'd0);
    end
    apb(0, 8'h10, 0, rd, err); check("t2_level", rd, 32'h10);
    apb(0, 8'h0C, 0, rd, err); check("t2_status", rd, 32'h6);
    apb(1, 8'h08, 32'h2, rd, err);
    apb(0, 8'h10, 0, rd, err); check("t2_flush_level", rd, 32'h0);

    // RX overflow and in-order drain
    apb(1, 8'h08, 32'h1, rd, err);
    for (int i = 0; i < 17; i++) rx_word(16'h200 + 16'(i));
    apb(0, 8'h10, 0, rd, err); check("t3_level", rd, 32'h0010_0000);
    apb(0, 8'h0C, 0, rd, err); check("t3_status", rd, 32'h19);
    for (int i = 0; i < 18; i++) begin
      apb(0, 8'h04, 0, rd, err);
      check($sformatf("t3_rd%0d_data", i), rd, (i < 16) ? 32'h200 + 32'(i) : 32'h0);
      check($sformatf("t3_rd%0d_err", i), 32'(err), (i < 16) ? 32'd0 : 32'd1);
    end
    apb(1, 8'h0C, 32'h10, rd, err);
    apb(0, 8'h0C, 0, rd, err); check("t3_ovf_clear", rd, 32'h5);

    // Staged word survives flush and enable=0
    bus.tx_ready = 1'b0;
    apb(1, 8'h00, 32'hBEEF, rd, err);
    apb(1, 8'h00, 32'hCAFE, rd, err);
    wait_valid("t4_valid_timeout");
    check("t4_data", 32'(bus.tx_data), 32'hBEEF);
    apb(1, 8'h08, 32'h2, rd, err);
    repeat (3) @(posedge clk);
    #1;
    check("t4_valid_held", 32'(bus.tx_valid), 32'd1);
    check("t4_data_held", 32'(bus.tx_data), 32'hBEEF);
    apb(0, 8'h10, 0, rd, err); check("t4_level", rd, 32'h0);
    @(negedge clk);
    bus.tx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_ready = 1'b0;
    check("t4_valid_cleared", 32'(bus.tx_valid), 32'd0);
    check("t4_de_hold", 32'(bus.de), 32'd1);
    for (int k = 1; k <= G; k++) begin
      @(posedge clk);
      #1;
      if (k == G - 1) check("t4_de_hold_last", 32'(bus.de), 32'd1);
      if (k == G)     check("t4_de_idle", 32'(bus.de), 32'd0);
    end

    // Echo discard while driving, then reset mid-SEND
    apb(1, 8'h08, 32'h1, rd, err);
    apb(1, 8'h00, 32'h5555, rd, err);
    for (int n = 0; n < 10 && !bus.de; n++) begin @(posedge clk); #1; end
    check("t5_de_on", 32'(bus.de), 32'd1);
    rx_word(16'h77);
    apb(0, 8'h10, 0, rd, err); check("t5_rx_level", rd >> 16, 32'h0);
    apb(0, 8'h0C, 0, rd, err); check("t5_rx_ovf", (rd >> 4) & 32'h1, 32'h0);
    wait_valid("t5_valid_timeout");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rst_de", 32'(bus.de), 32'd0);
    check("t5_rst_valid", 32'(bus.tx_valid), 32'd0);
    check("t5_rst_data", 32'(bus.tx_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    apb(0, 8'h0C, 0, rd, err); check("t5_rst_status", rd, 32'h5);
    apb(0, 8'h08, 0, rd, err); check("t5_rst_enable", rd, 32'h0);

`ifdef RS485_IRQ_EN
    check("t6_irq_reset", 32'(irq), 32'd0);
    apb(1, 8'h08, 32'h1, rd, err);
    apb(1, 8'h14, 32'h2, rd, err);
    apb(0, 8'h14, 0, rd, err); check("t6_mask", rd, 32'h2);
    rx_word(16'h42);
    check("t6_irq_same", 32'(irq), 32'd0);
    @(posedge clk);
    #1;
    check("t6_irq_set", 32'(irq), 32'd1);
    apb(0, 8'h04, 0, rd, err);
    check("t6_rd_data", rd, 32'h42);
    check("t6_irq_still", 32'(irq), 32'd1);
    @(posedge clk);
    #1;
    check("t6_irq_clear", 32'(irq), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
